// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe (plus package imm_gen_pkg)
// Brief    : RV32I/RV64I immediate generator between decode and execute.
//            Decodes the I/S/B/U/J immediate formats, sign-extends the
//            result to XLEN and holds it in a 2-entry skid buffer with a
//            valid/ready handshake on both sides.
// Ports    : clk          - clock, rising edge
//            reset_n      - asynchronous active-low reset
//            flush        - synchronous clear of all buffered entries
//            in_valid     - upstream word valid
//            in_ready     - block can accept (registered, state only)
//            instruction  - raw 32-bit instruction word
//            encoding     - encoding class (enc_t)
//            out_valid    - imm/err valid
//            out_ready    - downstream accepts
//            imm          - sign-extended immediate, XLEN bits
//            err          - encoding carries no immediate
// Revision : 1.0 - initial release
// ============================================================================

package imm_gen_pkg;
    typedef enum logic [2:0] {
        I_TYPE = 3'd0,
        S_TYPE = 3'd1,
        B_TYPE = 3'd2,
        U_TYPE = 3'd3,
        J_TYPE = 3'd4,
        R_TYPE = 3'd5
    } enc_t;
endpackage

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit J_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  enc_t            encoding,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_in_ready;
    logic [XLEN-1:0]   r_h_imm;
    logic              r_h_err;
    logic [XLEN-1:0]   r_s_imm;
    logic              r_s_err;

    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_err;
    logic              w_push;
    logic              w_pop;
    logic              w_load_head_new;
    logic              w_load_head_second;
    logic              w_load_second;
    logic              w_unused;

    // Opcode bits never contribute to an immediate.
    assign w_unused = ^instruction[6:0];

    // ------------------------------------------------------------------
    // Decode. Every format takes its sign from instruction[31], so the
    // 32-bit result can simply be sign-extended to XLEN afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        w_imm32 = 32'd0;
        w_err   = 1'b0;
        case (encoding)
            I_TYPE: w_imm32 = 32'($signed(instruction[31:20]));
            S_TYPE: w_imm32 = 32'($signed({instruction[31:25], instruction[11:7]}));
            B_TYPE: w_imm32 = 32'($signed({instruction[31], instruction[7],
                                            instruction[30:25], instruction[11:8], 1'b0}));
            U_TYPE: w_imm32 = {instruction[31:12], 12'd0};
            J_TYPE: begin
                if (J_ENABLE) begin
                    w_imm32 = 32'($signed({instruction[31], instruction[19:12],
                                            instruction[20], instruction[30:21], 1'b0}));
                end else begin
                    w_err = 1'b1;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_in_ready;
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Registered so in_ready never sees out_ready combinationally.
            r_in_ready <= (w_state_next != FULL);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_load_head_new    = 1'b0;
        w_load_head_second = 1'b0;
        w_load_second      = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_next    = ONE;
                        w_load_head_new = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_load_head_new = 1'b1;
                    end else if (w_push) begin
                        w_state_next  = FULL;
                        w_load_second = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_next       = ONE;
                        w_load_head_second = 1'b1;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: head drives the outputs, second is the skid slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_imm <= '0;
            r_h_err <= 1'b0;
            r_s_imm <= '0;
            r_s_err <= 1'b0;
        end else begin
            if (w_load_head_new) begin
                r_h_imm <= w_imm;
                r_h_err <= w_err;
            end else if (w_load_head_second) begin
                r_h_imm <= r_s_imm;
                r_h_err <= r_s_err;
            end
            if (w_load_second) begin
                r_s_imm <= w_imm;
                r_s_err <= w_err;
            end
        end
    end

    assign imm = r_h_imm;
    assign err = r_h_err;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Self-checking bench for imm_gen_pipe. Three instances share
//            the stimulus: XLEN=32, XLEN=64, and XLEN=32 with J disabled.
//            A queue-based reference model tracks buffer contents; a
//            vector table holds hand-derived results.
// Revision : 1.0 - initial release
// ============================================================================

module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    enc_t        encoding;
    logic        out_ready;

    logic        a_ir, a_ov, a_err;
    logic [31:0] a_imm;
    logic        b_ir, b_ov, b_err;
    logic [63:0] b_imm;
    logic        c_ir, c_ov, c_err;
    logic [31:0] c_imm;

    imm_gen_pipe #(.XLEN(32), .J_ENABLE(1'b1)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_ir), .instruction(instruction), .encoding(encoding),
        .out_valid(a_ov), .out_ready(out_ready), .imm(a_imm), .err(a_err)
    );

    imm_gen_pipe #(.XLEN(64), .J_ENABLE(1'b1)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_ir), .instruction(instruction), .encoding(encoding),
        .out_valid(b_ov), .out_ready(out_ready), .imm(b_imm), .err(b_err)
    );

    imm_gen_pipe #(.XLEN(32), .J_ENABLE(1'b0)) dutnj (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(c_ir), .instruction(instruction), .encoding(encoding),
        .out_valid(c_ov), .out_ready(out_ready), .imm(c_imm), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] ins;
        enc_t        enc;
    } item_t;

    item_t q[$];
    bit    m_ready;

    typedef struct {
        logic [31:0] ins;
        enc_t        enc;
        logic [63:0] exp64;
        logic        exp_err;
        logic        exp_err_nj;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the format rules; returns {err, imm64}.
    function automatic logic [64:0] ref_dec(input logic [31:0] in, input enc_t e, input bit jen);
        longint v;
        bit     er;
        v  = 0;
        er = 1'b0;
        case (e)
            I_TYPE: v = longint'($signed(in[31:20]));
            S_TYPE: v = longint'($signed({in[31:25], in[11:7]}));
            B_TYPE: v = longint'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
            U_TYPE: v = longint'($signed({in[31:12], 12'b0}));
            J_TYPE: begin
                if (jen) v = longint'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
                else     er = 1'b1;
            end
            default: er = 1'b1;
        endcase
        return {er, v};
    endfunction

    task automatic chk_dut(input string tag, input logic ov, input logic ir,
                           input logic [63:0] im, input logic er, input int xlen, input bit jen);
        logic [64:0] r;
        logic [63:0] e;
        chk({tag, ".out_valid"}, {63'd0, ov}, {63'd0, q.size() > 0});
        chk({tag, ".in_ready"}, {63'd0, ir}, {63'd0, m_ready});
        if (q.size() > 0) begin
            r = ref_dec(q[0].ins, q[0].enc, jen);
            e = (xlen == 32) ? {32'd0, r[31:0]} : r[63:0];
            chk({tag, ".imm"}, im, e);
            chk({tag, ".err"}, {63'd0, er}, {63'd0, r[64]});
        end
    endtask

    task automatic check_all();
        chk_dut("d32", a_ov, a_ir, {32'd0, a_imm}, a_err, 32, 1'b1);
        chk_dut("d64", b_ov, b_ir, b_imm, b_err, 64, 1'b1);
        chk_dut("dnj", c_ov, c_ir, {32'd0, c_imm}, c_err, 32, 1'b0);
    endtask

    // One clock: update the model on the edge, check #1 later, return at negedge.
    task automatic step();
        bit push, pop;
        @(posedge clk);
        push = in_valid && m_ready;
        pop  = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{instruction, encoding});
        end
        m_ready = (q.size() < 2);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst.out_valid", {61'd0, a_ov, b_ov, c_ov}, 64'd0);
        chk("rst.in_ready", {61'd0, a_ir, b_ir, c_ir}, 64'd0);
        chk("rst.imm32", {32'd0, a_imm}, 64'd0);
        chk("rst.imm64", b_imm, 64'd0);
        chk("rst.err", {61'd0, a_err, b_err, c_err}, 64'd0);
        q.delete();
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst.in_ready_low_after_release", {63'd0, a_ir}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        step();
    endtask

    task automatic offer(input logic [31:0] ins, input enc_t e);
        in_valid    = 1'b1;
        instruction = ins;
        encoding    = e;
    endtask

    initial begin
        reset_n     = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'd0;
        encoding    = I_TYPE;
        out_ready   = 1'b0;
        m_ready     = 1'b0;

        vecs[0] = '{32'hFFF00093, I_TYPE, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[1] = '{32'hFE112E23, S_TYPE, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
        vecs[2] = '{32'hFE000CE3, B_TYPE, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0};
        vecs[3] = '{32'h123452B7, U_TYPE, 64'h0000000012345000, 1'b0, 1'b0};
        vecs[4] = '{32'h001000EF, J_TYPE, 64'h0000000000000800, 1'b0, 1'b1};
        vecs[5] = '{32'h800002B7, U_TYPE, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
        vecs[6] = '{32'h002081B3, R_TYPE, 64'h0000000000000000, 1'b1, 1'b1};
        vecs[7] = '{32'hFFFFFFFF, enc_t'(3'd7), 64'h0000000000000000, 1'b1, 1'b1};

        #2;
        do_reset();

        // Back-to-back table, one result per cycle, one cycle after push.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            offer(vecs[k].ins, vecs[k].enc);
            step();
            chk($sformatf("vec%0d.imm32", k), {32'd0, a_imm}, {32'd0, vecs[k].exp64[31:0]});
            chk($sformatf("vec%0d.imm64", k), b_imm, vecs[k].exp64);
            chk($sformatf("vec%0d.err", k), {63'd0, a_err}, {63'd0, vecs[k].exp_err});
            chk($sformatf("vec%0d.err_nj", k), {63'd0, c_err}, {63'd0, vecs[k].exp_err_nj});
        end
        in_valid = 1'b0;
        step();

        // Backpressure: three offers, two accepted, drained in order.
        out_ready = 1'b0;
        offer(vecs[0].ins, vecs[0].enc); step();
        offer(vecs[3].ins, vecs[3].enc); step();
        chk("bp.in_ready_full", {63'd0, a_ir}, 64'd0);
        offer(vecs[1].ins, vecs[1].enc); step();
        chk("bp.hold_imm", {32'd0, a_imm}, 64'h00000000FFFFFFFF);
        step();
        chk("bp.hold_imm2", {32'd0, a_imm}, 64'h00000000FFFFFFFF);
        out_ready = 1'b1;
        step();
        chk("bp.second", {32'd0, a_imm}, 64'h0000000012345000);
        step();
        chk("bp.third", {32'd0, a_imm}, 64'h00000000FFFFFFFC);
        in_valid = 1'b0;
        step();
        chk("bp.drained", {63'd0, a_ov}, 64'd0);

        // Flush while FULL with a word on offer.
        out_ready = 1'b0;
        offer(vecs[1].ins, vecs[1].enc); step();
        offer(vecs[2].ins, vecs[2].enc); step();
        flush = 1'b1;
        offer(32'h7FF00093, I_TYPE);
        step();
        chk("flush.out_valid", {63'd0, a_ov}, 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush.no_ghost", {61'd0, a_ov, b_ov, c_ov}, 64'd0);

        // Reset asserted while FULL.
        out_ready = 1'b0;
        offer(vecs[4].ins, vecs[4].enc); step();
        offer(vecs[5].ins, vecs[5].enc); step();
        chk("prerst.full", {63'd0, a_ir}, 64'd0);
        do_reset();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom % 2) == 0;
            out_ready   = ($urandom % 4) != 0;
            flush       = ($urandom % 16) == 0;
            encoding    = enc_t'($urandom_range(0, 7));
            instruction = $urandom;
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
